// File: rtl/i2c_axil_xfer_if.sv
// AXI-lite bus (32-bit data, 4-bit address) between the transfer sequencer
// and the downstream I2C master's register port.
interface i2c_axil_xfer_if;
    logic [3:0]  awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [3:0]  araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/i2c_axil_xfer.sv
// Turns one I2C register read/write request into the DATA/CMD/STATUS access
// sequence of an AXI-lite I2C master, then returns a single response.
module i2c_axil_xfer #(
    parameter int POLL_LIMIT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  req_dev_addr,
    input  logic [7:0]  req_reg_addr,
    input  logic [7:0]  req_data,
    input  logic        req_read,
    input  logic        req_valid,
    output logic        req_ready,
    output logic [7:0]  rsp_data,
    output logic        rsp_nack,
    output logic        rsp_timeout,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    i2c_axil_xfer_if.master m_axil
);
    localparam int CW = $clog2(POLL_LIMIT + 1);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_SEQ       = 3'd1;
    localparam logic [2:0] ST_POLL_STAT = 3'd2;
    localparam logic [2:0] ST_POLL_DATA = 3'd3;
    localparam logic [2:0] ST_CLR_ACK   = 3'd4;
    localparam logic [2:0] ST_RESP      = 3'd5;

    // AXI sub-phase: launch (load address/data), address/data handshake, response wait
    localparam logic [1:0] PH_LAUNCH = 2'd0;
    localparam logic [1:0] PH_ADDR   = 2'd1;
    localparam logic [1:0] PH_RESP   = 2'd2;

    logic [2:0]    state_reg;
    logic [1:0]    phase_reg;
    logic [1:0]    step_reg;
    logic [6:0]    dev_reg;
    logic [7:0]    reg_addr_reg;
    logic [7:0]    wr_byte_reg;
    logic          read_reg;
    logic [CW-1:0] poll_cnt_reg;
    logic          req_ready_reg;
    logic [7:0]    rsp_data_reg;
    logic          rsp_nack_reg;
    logic          rsp_timeout_reg;
    logic [3:0]    awaddr_reg;
    logic [31:0]   wdata_reg;
    logic          awvalid_reg;
    logic          wvalid_reg;
    logic          bready_reg;
    logic [3:0]    araddr_reg;
    logic          arvalid_reg;
    logic          rready_reg;

    logic [3:0]    wr_addr;
    logic [31:0]   wr_data;
    logic          last_poll;
    logic          stat_idle;
    logic          ack_now;
    logic          unused_rdata;

    always_comb begin
        wr_addr = 4'h0;
        wr_data = 32'h0;
        if (state_reg == ST_CLR_ACK) begin
            wr_addr = 4'h0;
            wr_data = 32'h8;
        end else begin
            case ({read_reg, step_reg})
                3'b0_00: begin wr_addr = 4'h8; wr_data = 32'h100  | {24'h0, reg_addr_reg}; end
                3'b0_01: begin wr_addr = 4'h8; wr_data = 32'h300  | {24'h0, wr_byte_reg};  end
                3'b0_10: begin wr_addr = 4'h4; wr_data = 32'h1900 | {25'h0, dev_reg};      end
                3'b1_00: begin wr_addr = 4'h8; wr_data = 32'h300  | {24'h0, reg_addr_reg}; end
                3'b1_01: begin wr_addr = 4'h4; wr_data = 32'h900  | {25'h0, dev_reg};      end
                3'b1_10: begin wr_addr = 4'h4; wr_data = 32'h1300 | {25'h0, dev_reg};      end
                default: ;
            endcase
        end
    end

    assign last_poll = (poll_cnt_reg == CW'(POLL_LIMIT - 1));
    // A missed ACK with the master no longer busy ends the transfer even if
    // the command FIFO still holds the abandoned commands.
    assign stat_idle = !m_axil.rdata[0] && (m_axil.rdata[8] || m_axil.rdata[3]);
    assign ack_now   = rsp_nack_reg || m_axil.rdata[3];
    assign unused_rdata = ^m_axil.rdata[31:9];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            phase_reg       <= PH_LAUNCH;
            step_reg        <= 2'd0;
            dev_reg         <= 7'h0;
            reg_addr_reg    <= 8'h0;
            wr_byte_reg     <= 8'h0;
            read_reg        <= 1'b0;
            poll_cnt_reg    <= '0;
            req_ready_reg   <= 1'b0;
            rsp_data_reg    <= 8'h0;
            rsp_nack_reg    <= 1'b0;
            rsp_timeout_reg <= 1'b0;
            awaddr_reg      <= 4'h0;
            wdata_reg       <= 32'h0;
            awvalid_reg     <= 1'b0;
            wvalid_reg      <= 1'b0;
            bready_reg      <= 1'b0;
            araddr_reg      <= 4'h0;
            arvalid_reg     <= 1'b0;
            rready_reg      <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    req_ready_reg <= !(req_valid && req_ready_reg);
                    if (req_valid && req_ready_reg) begin
                        dev_reg         <= req_dev_addr;
                        reg_addr_reg    <= req_reg_addr;
                        wr_byte_reg     <= req_data;
                        read_reg        <= req_read;
                        poll_cnt_reg    <= '0;
                        rsp_data_reg    <= 8'h0;
                        rsp_nack_reg    <= 1'b0;
                        rsp_timeout_reg <= 1'b0;
                        step_reg        <= 2'd0;
                        phase_reg       <= PH_LAUNCH;
                        state_reg       <= ST_SEQ;
                    end
                end
                ST_SEQ, ST_CLR_ACK: begin
                    case (phase_reg)
                        PH_LAUNCH: begin
                            awaddr_reg  <= wr_addr;
                            wdata_reg   <= wr_data;
                            awvalid_reg <= 1'b1;
                            wvalid_reg  <= 1'b1;
                            phase_reg   <= PH_ADDR;
                        end
                        PH_ADDR: begin
                            if (awvalid_reg && m_axil.awready) awvalid_reg <= 1'b0;
                            if (wvalid_reg && m_axil.wready)   wvalid_reg  <= 1'b0;
                            if ((!awvalid_reg || m_axil.awready) && (!wvalid_reg || m_axil.wready)) begin
                                bready_reg <= 1'b1;
                                phase_reg  <= PH_RESP;
                            end
                        end
                        default: begin
                            if (m_axil.bvalid) begin
                                bready_reg <= 1'b0;
                                phase_reg  <= PH_LAUNCH;
                                if (m_axil.bresp != 2'b00) begin
                                    rsp_timeout_reg <= 1'b1;
                                    state_reg       <= ST_RESP;
                                end else if (state_reg == ST_CLR_ACK) begin
                                    state_reg <= ST_RESP;
                                end else if (step_reg == 2'd2) begin
                                    state_reg <= ST_POLL_STAT;
                                end else begin
                                    step_reg <= step_reg + 2'd1;
                                end
                            end
                        end
                    endcase
                end
                ST_POLL_STAT, ST_POLL_DATA: begin
                    case (phase_reg)
                        PH_LAUNCH: begin
                            araddr_reg  <= (state_reg == ST_POLL_STAT) ? 4'h0 : 4'h8;
                            arvalid_reg <= 1'b1;
                            phase_reg   <= PH_ADDR;
                        end
                        PH_ADDR: begin
                            if (m_axil.arready) begin
                                arvalid_reg <= 1'b0;
                                rready_reg  <= 1'b1;
                                phase_reg   <= PH_RESP;
                            end
                        end
                        default: begin
                            if (m_axil.rvalid) begin
                                rready_reg   <= 1'b0;
                                phase_reg    <= PH_LAUNCH;
                                poll_cnt_reg <= poll_cnt_reg + 1'b1;
                                if (state_reg == ST_POLL_STAT) begin
                                    if (m_axil.rresp != 2'b00) begin
                                        rsp_timeout_reg <= 1'b1;
                                        state_reg <= rsp_nack_reg ? ST_CLR_ACK : ST_RESP;
                                    end else begin
                                        if (m_axil.rdata[3]) rsp_nack_reg <= 1'b1;
                                        if (stat_idle) begin
                                            state_reg <= ack_now ? ST_CLR_ACK :
                                                         (read_reg ? ST_POLL_DATA : ST_RESP);
                                        end else if (last_poll) begin
                                            rsp_timeout_reg <= 1'b1;
                                            state_reg <= ack_now ? ST_CLR_ACK : ST_RESP;
                                        end
                                    end
                                end else begin
                                    if (m_axil.rresp != 2'b00) begin
                                        rsp_timeout_reg <= 1'b1;
                                        state_reg       <= ST_RESP;
                                    end else if (m_axil.rdata[8]) begin
                                        rsp_data_reg <= m_axil.rdata[7:0];
                                        state_reg    <= ST_RESP;
                                    end else if (last_poll) begin
                                        rsp_timeout_reg <= 1'b1;
                                        state_reg       <= ST_RESP;
                                    end
                                end
                            end
                        end
                    endcase
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state_reg     <= ST_IDLE;
                        req_ready_reg <= 1'b1;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign req_ready   = req_ready_reg;
    assign rsp_valid   = (state_reg == ST_RESP);
    assign rsp_data    = rsp_data_reg;
    assign rsp_nack    = rsp_nack_reg;
    assign rsp_timeout = rsp_timeout_reg;

    assign m_axil.awaddr  = awaddr_reg;
    assign m_axil.awprot  = 3'b000;
    assign m_axil.awvalid = awvalid_reg;
    assign m_axil.wdata   = wdata_reg;
    assign m_axil.wstrb   = 4'hF;
    assign m_axil.wvalid  = wvalid_reg;
    assign m_axil.bready  = bready_reg;
    assign m_axil.araddr  = araddr_reg;
    assign m_axil.arprot  = 3'b000;
    assign m_axil.arvalid = arvalid_reg;
    assign m_axil.rready  = rready_reg;
endmodule

// File: tb/tb_i2c_axil_xfer.sv
// Directed bench for i2c_axil_xfer: a scripted AXI-lite slave with optional
// random stalls logs every register write and answers STATUS/DATA polls.
module tb_i2c_axil_xfer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] req_dev_addr = '0;
    logic [7:0] req_reg_addr = '0;
    logic [7:0] req_data = '0;
    logic       req_read = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [7:0] rsp_data;
    logic       rsp_nack;
    logic       rsp_timeout;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;

    always #5 clk = ~clk;

    i2c_axil_xfer_if bus();

    i2c_axil_xfer #(.POLL_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .req_dev_addr(req_dev_addr), .req_reg_addr(req_reg_addr),
        .req_data(req_data), .req_read(req_read),
        .req_valid(req_valid), .req_ready(req_ready),
        .rsp_data(rsp_data), .rsp_nack(rsp_nack), .rsp_timeout(rsp_timeout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .m_axil(bus)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- scripted AXI-lite slave ----------------
    bit          stall_en = 1'b0;
    logic [31:0] rnd;
    logic [35:0] wr_log[$];
    logic [31:0] stat_q[$];
    logic [31:0] data_q[$];
    logic [31:0] stat_dflt = 32'h100;
    logic [31:0] data_dflt = 32'h0;
    int          n_stat = 0;
    int          n_data = 0;
    logic        aw_d, w_d, b_pend, ar_pend;
    logic [3:0]  wa, ra;
    logic [31:0] wd;

    wire        aw_hs   = bus.awvalid && bus.awready;
    wire        w_hs    = bus.wvalid && bus.wready;
    wire        ar_hs   = bus.arvalid && bus.arready;
    wire        aw_now  = aw_d || aw_hs;
    wire        w_now   = w_d || w_hs;
    wire        wr_done = aw_now && w_now;
    wire [3:0]  wa_now  = aw_hs ? bus.awaddr : wa;
    wire [31:0] wd_now  = w_hs ? bus.wdata : wd;
    wire        b_go    = (b_pend || wr_done) && rnd[2];
    wire        ar_now  = ar_pend || ar_hs;
    wire [3:0]  ra_now  = ar_hs ? bus.araddr : ra;
    wire        r_go    = ar_now && rnd[4];

    always @(negedge clk) rnd <= stall_en ? $urandom : 32'hFFFF_FFFF;

    always @(posedge clk) begin
        if (rst) begin
            bus.awready <= 1'b0; bus.wready <= 1'b0; bus.bvalid <= 1'b0;
            bus.arready <= 1'b0; bus.rvalid <= 1'b0; bus.bresp  <= 2'b00;
            bus.rresp   <= 2'b00; bus.rdata <= 32'h0;
            aw_d <= 1'b0; w_d <= 1'b0; b_pend <= 1'b0; ar_pend <= 1'b0;
            wa <= 4'h0; ra <= 4'h0; wd <= 32'h0;
        end else begin
            if (aw_hs) wa <= bus.awaddr;
            if (w_hs)  wd <= bus.wdata;
            if (wr_done) wr_log.push_back({wa_now, wd_now});
            aw_d        <= aw_now && !wr_done;
            w_d         <= w_now && !wr_done;
            bus.awready <= !(aw_now && !wr_done) && rnd[0];
            bus.wready  <= !(w_now && !wr_done) && rnd[1];
            if (bus.bvalid && bus.bready) bus.bvalid <= 1'b0;
            if (b_go) bus.bvalid <= 1'b1;
            b_pend <= (b_pend || wr_done) && !b_go;

            if (ar_hs) ra <= bus.araddr;
            if (bus.rvalid && bus.rready) bus.rvalid <= 1'b0;
            if (r_go) begin
                bus.rvalid <= 1'b1;
                if (ra_now == 4'h0) begin
                    n_stat <= n_stat + 1;
                    if (stat_q.size() != 0) bus.rdata <= stat_q.pop_front();
                    else                    bus.rdata <= stat_dflt;
                end else begin
                    n_data <= n_data + 1;
                    if (data_q.size() != 0) bus.rdata <= data_q.pop_front();
                    else                    bus.rdata <= data_dflt;
                end
            end
            ar_pend     <= ar_now && !r_go;
            bus.arready <= !(ar_now && !r_go) && rnd[3];
        end
    end

    // ---------------- hold-until-handshake checks ----------------
    logic        p_aw = 1'b0, p_w = 1'b0, p_ar = 1'b0, p_rsp = 1'b0;
    logic [3:0]  p_awaddr, p_araddr;
    logic [31:0] p_wdata;
    logic [9:0]  p_rsp_bits;

    always @(posedge clk) begin
        p_aw       <= bus.awvalid && !bus.awready && !rst;
        p_w        <= bus.wvalid && !bus.wready && !rst;
        p_ar       <= bus.arvalid && !bus.arready && !rst;
        p_rsp      <= rsp_valid && !rsp_ready && !rst;
        p_awaddr   <= bus.awaddr;
        p_wdata    <= bus.wdata;
        p_araddr   <= bus.araddr;
        p_rsp_bits <= {rsp_data, rsp_nack, rsp_timeout};
    end

    always @(negedge clk) begin
        if (p_aw)  chk("aw_hold",  {bus.awvalid, bus.awaddr}, {1'b1, p_awaddr});
        if (p_w)   chk("w_hold",   {bus.wvalid, bus.wdata},   {1'b1, p_wdata});
        if (p_ar)  chk("ar_hold",  {bus.arvalid, bus.araddr}, {1'b1, p_araddr});
        if (p_rsp) chk("rsp_hold", {rsp_valid, rsp_data, rsp_nack, rsp_timeout}, {1'b1, p_rsp_bits});
    end

    // ---------------- request/response driver ----------------
    task automatic run_req(input logic rd, input logic [6:0] dev, input logic [7:0] ra_,
                           input logic [7:0] wd_, output logic [7:0] od,
                           output logic on, output logic ot);
        int n;
        od = 8'h0; on = 1'b0; ot = 1'b0;
        n = 0;
        while (!req_ready && n < 100) begin @(negedge clk); n++; end
        if (!req_ready) begin chk("req_ready_wait", req_ready, 1); return; end
        req_dev_addr = dev; req_reg_addr = ra_; req_data = wd_; req_read = rd;
        req_valid = 1'b1;
        @(posedge clk); #1 req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 2000) begin @(negedge clk); n++; end
        if (!rsp_valid) begin chk("rsp_valid_wait", rsp_valid, 1); return; end
        od = rsp_data; on = rsp_nack; ot = rsp_timeout;
        repeat (stall_en ? $urandom_range(0, 3) : 1) @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk); #1 rsp_ready = 1'b0;
        @(negedge clk);
        chk("rsp_valid_drop", rsp_valid, 0);
        chk("req_ready_after_rsp", req_ready, 1);
    endtask

    task automatic do_test(input string tag, input logic rd, input logic [6:0] dev,
                           input logic [7:0] ra_, input logic [7:0] wd_, input int exp_nw,
                           input logic [35:0] e0, input logic [35:0] e1,
                           input logic [35:0] e2, input logic [35:0] e3,
                           input int exp_ns, input int exp_nd, input logic [7:0] exp_d,
                           input logic exp_n, input logic exp_t);
        int wb, sb, db;
        logic [7:0] d;
        logic n, t;
        logic [35:0] ev[4];
        logic [35:0] got;
        ev = '{e0, e1, e2, e3};
        wb = wr_log.size(); sb = n_stat; db = n_data;
        run_req(rd, dev, ra_, wd_, d, n, t);
        $display("%s: dev=%h reg=%h rd=%0d -> data=%h nack=%0d timeout=%0d writes=%0d status_reads=%0d data_reads=%0d",
                 tag, dev, ra_, rd, d, n, t, wr_log.size() - wb, n_stat - sb, n_data - db);
        chk({tag, "_nwrites"}, wr_log.size() - wb, exp_nw);
        for (int i = 0; i < exp_nw; i++) begin
            got = (wb + i < wr_log.size()) ? wr_log[wb + i] : {36{1'bx}};
            chk($sformatf("%s_wr%0d", tag, i), got, ev[i]);
        end
        chk({tag, "_status_reads"}, n_stat - sb, exp_ns);
        chk({tag, "_data_reads"}, n_data - db, exp_nd);
        chk({tag, "_rsp_data"}, d, exp_d);
        chk({tag, "_rsp_nack"}, n, exp_n);
        chk({tag, "_rsp_timeout"}, t, exp_t);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_awvalid", bus.awvalid, 0);
        chk("rst_wvalid", bus.wvalid, 0);
        chk("rst_arvalid", bus.arvalid, 0);
        chk("rst_bready_rready", {bus.bready, bus.rready}, 0);
        chk("rst_rsp", {rsp_valid, rsp_data, rsp_nack, rsp_timeout}, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("req_ready_after_rst", req_ready, 1);

        stat_q.push_back(32'h100);
        do_test("wr", 0, 7'h50, 8'h12, 8'hA5, 3, {4'h8, 32'h112}, {4'h8, 32'h3A5},
                {4'h4, 32'h1950}, 36'h0, 1, 0, 8'h00, 0, 0);

        stat_q.push_back(32'h001); stat_q.push_back(32'h100);
        data_q.push_back(32'h0AB); data_q.push_back(32'h15A);
        do_test("rd", 1, 7'h50, 8'h34, 8'h00, 3, {4'h8, 32'h334}, {4'h4, 32'h950},
                {4'h4, 32'h1350}, 36'h0, 2, 2, 8'h5A, 0, 0);

        stat_q.push_back(32'h108);
        do_test("wr_nack", 0, 7'h2C, 8'h07, 8'h3C, 4, {4'h8, 32'h107}, {4'h8, 32'h33C},
                {4'h4, 32'h192C}, {4'h0, 32'h8}, 1, 0, 8'h00, 1, 0);

        stat_q.push_back(32'h008);
        do_test("rd_nack", 1, 7'h50, 8'h34, 8'h00, 4, {4'h8, 32'h334}, {4'h4, 32'h950},
                {4'h4, 32'h1350}, {4'h0, 32'h8}, 1, 0, 8'h00, 1, 0);

        stat_dflt = 32'h001;
        do_test("wr_timeout", 0, 7'h50, 8'h12, 8'hA5, 3, {4'h8, 32'h112}, {4'h8, 32'h3A5},
                {4'h4, 32'h1950}, 36'h0, 4, 0, 8'h00, 0, 1);
        stat_dflt = 32'h100;

        stat_q.push_back(32'h100);
        do_test("rd_data_timeout", 1, 7'h50, 8'h34, 8'h00, 3, {4'h8, 32'h334}, {4'h4, 32'h950},
                {4'h4, 32'h1350}, 36'h0, 1, 3, 8'h00, 0, 1);

        stall_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            stat_q.push_back(32'h100);
            do_test($sformatf("stall_wr%0d", k), 0, 7'h50, 8'h12, 8'hA5, 3, {4'h8, 32'h112},
                    {4'h8, 32'h3A5}, {4'h4, 32'h1950}, 36'h0, 1, 0, 8'h00, 0, 0);
            stat_q.push_back(32'h001); stat_q.push_back(32'h100);
            data_q.push_back(32'h0AB); data_q.push_back(32'h15A);
            do_test($sformatf("stall_rd%0d", k), 1, 7'h50, 8'h34, 8'h00, 3, {4'h8, 32'h334},
                    {4'h4, 32'h950}, {4'h4, 32'h1350}, 36'h0, 2, 2, 8'h5A, 0, 0);
        end

        // reset while the first DATA write is on the bus
        req_dev_addr = 7'h50; req_reg_addr = 8'h12; req_data = 8'hA5; req_read = 1'b0;
        req_valid = 1'b1;
        @(posedge clk); #1 req_valid = 1'b0;
        n = 0;
        while (!bus.awvalid && n < 50) begin @(negedge clk); n++; end
        chk("mid_seq_awvalid_seen", bus.awvalid, 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        $display("mid_seq_rst: awvalid=%0d wvalid=%0d arvalid=%0d req_ready=%0d",
                 bus.awvalid, bus.wvalid, bus.arvalid, req_ready);
        chk("mid_rst_valids", {bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready, rsp_valid}, 0);
        chk("mid_rst_req_ready", req_ready, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_req_ready_after", req_ready, 1);
        stall_en = 1'b0;

        stat_q.push_back(32'h100);
        do_test("post_rst_wr", 0, 7'h50, 8'h12, 8'hA5, 3, {4'h8, 32'h112}, {4'h8, 32'h3A5},
                {4'h4, 32'h1950}, 36'h0, 1, 0, 8'h00, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
